// File: rtl/fx_noise_gate.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fx_noise_gate
//  Purpose  : Stereo noise gate. The louder channel's magnitude drives a
//             five-state gate (CLOSED/ATTACK/OPEN/HOLD/RELEASE) that ramps
//             a 0..256 gain applied to both channels. All state advances
//             only on sample_en strobes.
//  Ports    : clk           system clock
//             reset_n       synchronous active-low reset
//             audio_in      stereo samples, [0]=L, [1]=R, two's complement
//             audio_out     gated stereo samples, registered, 1-cycle latency
//             fx_threshold  gate open threshold (level >= threshold<<8)
//             fx_attack     strobes per +1 gain step minus one, in ATTACK
//             fx_hold       hold time in units of 64 strobes
//             fx_release    strobes per -1 gain step minus one, in RELEASE
//             sample_en     one-cycle strobe marking a valid sample
//  Revision : 1.0  initial release
// ============================================================================
module fx_noise_gate #(
    parameter int DATA_W  = 16,
    parameter int PARAM_W = 7
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0][DATA_W-1:0] audio_in,
    output logic [1:0][DATA_W-1:0] audio_out,
    input  logic [PARAM_W-1:0]     fx_threshold,
    input  logic [PARAM_W-1:0]     fx_attack,
    input  logic [PARAM_W-1:0]     fx_hold,
    input  logic [PARAM_W-1:0]     fx_release,
    input  logic                   sample_en
);

    localparam int LVL_W  = DATA_W - 1;
    localparam int GAIN_W = 9;
    localparam int HOLD_W = PARAM_W + 6;
    localparam int PROD_W = DATA_W + GAIN_W + 1;

    localparam logic [GAIN_W-1:0]  GAIN_MAX = 9'd256;
    localparam logic [LVL_W-1:0]   LVL_ONE  = 1;
    localparam logic [PARAM_W-1:0] RATE_ONE = 1;
    localparam logic [HOLD_W-1:0]  HOLD_ONE = 1;

    typedef enum logic [2:0] {
        S_CLOSED  = 3'd0,
        S_ATTACK  = 3'd1,
        S_OPEN    = 3'd2,
        S_HOLD    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [GAIN_W-1:0]        gain_q,  gain_d;
    logic [PARAM_W-1:0]       rate_q,  rate_d;
    logic [HOLD_W-1:0]        hold_q,  hold_d;
    logic [1:0][DATA_W-1:0]   audio_q, audio_d;

    logic [1:0][LVL_W-1:0]    abs_w;
    logic [1:0][DATA_W-1:0]   scaled_w;
    logic [LVL_W-1:0]         level_w;
    logic [LVL_W-1:0]         open_th_w;
    logic [LVL_W-1:0]         close_th_w;

    // Per-channel magnitude and gain scaling.
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic                     is_min_w;
        logic signed [PROD_W-1:0] prod_w;

        // The most negative sample has no positive counterpart in LVL_W
        // bits, so it saturates to the largest representable level.
        assign is_min_w   = audio_in[ch][DATA_W-1] && (audio_in[ch][LVL_W-1:0] == '0);
        assign abs_w[ch]  = is_min_w                ? '1 :
                            audio_in[ch][DATA_W-1]  ? (~audio_in[ch][LVL_W-1:0] + LVL_ONE) :
                                                      audio_in[ch][LVL_W-1:0];

        // Full-width signed product; gain is zero-extended so it stays positive.
        assign prod_w = $signed({{(GAIN_W+1){audio_in[ch][DATA_W-1]}}, audio_in[ch]})
                      * $signed({{(DATA_W+1){1'b0}}, gain_q});
        assign scaled_w[ch] = DATA_W'(prod_w >>> 8);
    end

    assign level_w    = (abs_w[0] >= abs_w[1]) ? abs_w[0] : abs_w[1];
    assign open_th_w  = LVL_W'({fx_threshold, 8'b0});
    assign close_th_w = open_th_w >> 1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_CLOSED;
            gain_q  <= '0;
            rate_q  <= '0;
            hold_q  <= '0;
            audio_q <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            rate_q  <= rate_d;
            hold_q  <= hold_d;
            audio_q <= audio_d;
        end
    end

    // Rate dividers compare with >= so that lowering fx_attack/fx_release
    // below the running count takes effect on the very next strobe.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        rate_d  = rate_q;
        hold_d  = hold_q;
        audio_d = audio_q;

        if (sample_en) begin
            // Output uses the gain held before this strobe's update.
            audio_d = scaled_w;

            case (state_q)
                S_CLOSED: begin
                    gain_d = '0;
                    if (level_w >= open_th_w) begin
                        state_d = S_ATTACK;
                        rate_d  = '0;
                    end
                end

                S_ATTACK: begin
                    if (gain_q >= GAIN_MAX) begin
                        gain_d  = GAIN_MAX;
                        state_d = S_OPEN;
                        rate_d  = '0;
                    end else if (rate_q >= fx_attack) begin
                        gain_d = gain_q + 9'd1;
                        rate_d = '0;
                        if (gain_q == GAIN_MAX - 9'd1) begin
                            state_d = S_OPEN;
                        end
                    end else begin
                        rate_d = rate_q + RATE_ONE;
                    end
                end

                S_OPEN: begin
                    gain_d = GAIN_MAX;
                    if (level_w < close_th_w) begin
                        state_d = S_HOLD;
                        hold_d  = {fx_hold, 6'b0};
                        rate_d  = '0;
                    end
                end

                S_HOLD: begin
                    gain_d = GAIN_MAX;
                    if (level_w >= open_th_w) begin
                        state_d = S_OPEN;
                        rate_d  = '0;
                    end else if (hold_q == '0) begin
                        state_d = S_RELEASE;
                        rate_d  = '0;
                    end else begin
                        hold_d = hold_q - HOLD_ONE;
                    end
                end

                S_RELEASE: begin
                    if (level_w >= open_th_w) begin
                        // Re-attack resumes from the current gain.
                        state_d = S_ATTACK;
                        rate_d  = '0;
                    end else if (gain_q == '0) begin
                        state_d = S_CLOSED;
                        rate_d  = '0;
                    end else if (rate_q >= fx_release) begin
                        gain_d = gain_q - 9'd1;
                        rate_d = '0;
                        if (gain_q == 9'd1) begin
                            state_d = S_CLOSED;
                        end
                    end else begin
                        rate_d = rate_q + RATE_ONE;
                    end
                end

                default: begin
                    state_d = S_CLOSED;
                    gain_d  = '0;
                    rate_d  = '0;
                end
            endcase
        end
    end

    assign audio_out = audio_q;

endmodule
`default_nettype wire

// File: tb/tb_fx_noise_gate.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fx_noise_gate
//  Purpose  : Self-checking bench for fx_noise_gate. Directed strobes push
//             hand-derived expected outputs into a queue; a monitor pops and
//             compares one entry after every accepted strobe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fx_noise_gate;

    localparam int DW = 16;
    localparam int PW = 7;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [1:0][DW-1:0]  audio_in;
    logic [1:0][DW-1:0]  audio_out;
    logic [PW-1:0]       thr, att, hld, rel;
    logic                sample_en;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    fx_noise_gate #(.DATA_W(DW), .PARAM_W(PW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .audio_in     (audio_in),
        .audio_out    (audio_out),
        .fx_threshold (thr),
        .fx_attack    (att),
        .fx_hold      (hld),
        .fx_release   (rel),
        .sample_en    (sample_en)
    );

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // (x * g) >>> 8 for a signed sample and a hand-chosen gain.
    function automatic logic [DW-1:0] scale(input logic [DW-1:0] x, input int g);
        int p;
        p = int'($signed(x)) * g;
        return DW'(p >>> 8);
    endfunction

    task automatic strobe(input logic [DW-1:0] l, input logic [DW-1:0] r,
                          input logic [DW-1:0] el, input logic [DW-1:0] er,
                          input string nm);
        exp_t e;
        e.l = el;
        e.r = er;
        exp_q.push_back(e);
        name_q.push_back(nm);
        audio_in[0] = l;
        audio_in[1] = r;
        sample_en   = 1'b1;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    // Monitor: every strobe accepted out of reset yields one output update.
    always @(posedge clk) begin
        if (reset_n === 1'b1 && sample_en === 1'b1) begin
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow: got %h/%h expected no output", audio_out[0], audio_out[1]);
            end else begin
                exp_t  e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check({n, "_L"}, audio_out[0], e.l);
                check({n, "_R"}, audio_out[1], e.r);
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        sample_en   = 1'b0;
        audio_in[0] = 16'h7FFF;
        audio_in[1] = 16'h7FFF;
        thr = 7'h40;
        att = 7'd0;
        hld = 7'd2;
        rel = 7'd1;

        // Reset held with strobes pulsing: output stays zero.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("rst_L", audio_out[0], 16'h0000);
            check("rst_R", audio_out[1], 16'h0000);
            sample_en = ~sample_en;
        end
        sample_en = 1'b0;
        reset_n   = 1'b1;

        // First strobe after reset: gain 0; loud input starts ATTACK.
        strobe(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, "first_after_rst");
        strobe(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, "atk_g0");
        strobe(16'h7FFF, 16'h7FFF, 16'd127,  16'd127,  "atk_g1");
        strobe(16'h7FFF, 16'h7FFF, 16'd255,  16'd255,  "atk_g2");

        // Reset mid-ATTACK with a strobe present: reset wins.
        reset_n   = 1'b0;
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        check("rst_midatk_L", audio_out[0], 16'h0000);
        check("rst_midatk_R", audio_out[1], 16'h0000);
        reset_n   = 1'b1;
        sample_en = 1'b0;

        // Attack ramp at divider 0: +64 per strobe, then unity.
        strobe(16'h4000, 16'h4000, 16'h0000, 16'h0000, "r30_enter");
        for (int k = 1; k <= 256; k++) begin
            strobe(16'h4000, 16'h4000, 16'(64*(k-1)), 16'(64*(k-1)), "r30_ramp");
        end
        strobe(16'h4000, 16'h4000, 16'h4000, 16'h4000, "r30_open");

        // Most negative sample passes bit-exact; gate stays open.
        strobe(16'h8000, 16'h0000, 16'h8000, 16'h0000, "r33_min");
        strobe(16'h4000, 16'h4000, 16'h4000, 16'h4000, "r33_still_open");

        // No strobes: output frozen regardless of input.
        for (int i = 0; i < 50; i++) begin
            audio_in[0] = 16'($urandom);
            audio_in[1] = 16'($urandom);
            @(posedge clk);
            #1;
            check("r34_idle_L", audio_out[0], 16'h4000);
            check("r34_idle_R", audio_out[1], 16'h4000);
        end
        strobe(16'h4000, 16'h4000, 16'h4000, 16'h4000, "r34_after");

        // Quiet input (below close_th 0x2000): hold 129 strobes, then
        // release one step every 2 strobes; stop at gain 100.
        strobe(16'h1000, 16'h1000, 16'h1000, 16'h1000, "r31_drop");
        for (int h = 1; h <= 129; h++) begin
            strobe(16'h1000, 16'h1000, 16'h1000, 16'h1000, "r31_hold");
        end
        for (int j = 1; j <= 312; j++) begin
            strobe(16'h1000, 16'h1000, 16'(16*(256-(j-1)/2)), 16'(16*(256-(j-1)/2)), "r31_rel_a");
        end

        // Re-attack from gain 100.
        strobe(16'h4000, 16'h4000, 16'h1900, 16'h1900, "r32_reattack");
        strobe(16'h4000, 16'h4000, 16'h1900, 16'h1900, "r32_next");
        for (int g = 101; g <= 255; g++) begin
            strobe(16'h4000, 16'h4000, scale(16'h4000, g), scale(16'h4000, g), "r32_ramp");
        end
        strobe(16'h4000, 16'h4000, 16'h4000, 16'h4000, "r32_open");

        // Full hold + release down to CLOSED.
        strobe(16'h1000, 16'h1000, 16'h1000, 16'h1000, "r31_drop2");
        for (int h = 1; h <= 129; h++) begin
            strobe(16'h1000, 16'h1000, 16'h1000, 16'h1000, "r31_hold2");
        end
        for (int j = 1; j <= 512; j++) begin
            strobe(16'h1000, 16'h1000, 16'(16*(256-(j-1)/2)), 16'(16*(256-(j-1)/2)), "r31_rel_b");
        end
        strobe(16'h1000, 16'h1000, 16'h0000, 16'h0000, "r31_closed");
        strobe(16'h1000, 16'h1000, 16'h0000, 16'h0000, "r31_closed2");

        // Threshold 0 opens on any level; attack divider 1 -> step per 2 strobes.
        thr = 7'd0;
        att = 7'd1;
        strobe(16'h0100, 16'hFF00, 16'h0000, 16'h0000, "thr0_enter");
        for (int k = 1; k <= 512; k++) begin
            strobe(16'h0100, 16'hFF00, 16'((k-1)/2), 16'(-((k-1)/2)), "thr0_ramp");
        end
        strobe(16'h0100, 16'hFF00, 16'h0100, 16'hFF00, "thr0_open");

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fx_noise_gate.md
FX_NOISE_GATE -- requirements
Module: fx_noise_gate

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, audio sample width; PARAM_W, default 7, control parameter width.
REQ-002 Port: clk  input  1  system clock; the block SHALL use this single clock.
REQ-003 Port: reset_n  input  1  reset, synchronous and active-low.
REQ-004 Port: audio_in  input  [1:0][DATA_W-1:0]  stereo two's-complement samples; index 0 is L, index 1 is R.
REQ-005 Port: audio_out  output  [1:0][DATA_W-1:0]  gated stereo samples, registered; feeds the compressor input.
REQ-006 Port: fx_threshold  input  PARAM_W  gate open threshold.
REQ-007 Port: fx_attack  input  PARAM_W  attack rate divider.
REQ-008 Port: fx_hold  input  PARAM_W  hold time.
REQ-009 Port: fx_release  input  PARAM_W  release rate divider.
REQ-010 Port: sample_en  input  1  one-cycle strobe marking a valid audio_in sample.

Function
REQ-011 All state SHALL update only in cycles where sample_en=1; with sample_en=0 every register, including audio_out, SHALL hold.
REQ-012 Level SHALL be max(|L|,|R|) as a 15-bit unsigned value; |-32768| SHALL saturate to 32767.
REQ-013 open_th SHALL be fx_threshold<<8 (15 bit); close_th SHALL be open_th>>1 (hysteresis).
REQ-014 Gain SHALL be a 9-bit unsigned value in the range 0..256, where 256 is unity.
REQ-015 On a strobe, audio_out[ch] SHALL be (audio_in[ch]*gain)>>>8 (arithmetic shift, signed), using the gain value before that strobe's update; latency is 1 cycle.
REQ-016 At gain=256 the output SHALL be bit-exact to the input; at gain=0 the output SHALL be 0.
REQ-017 FSM states SHALL be CLOSED, ATTACK, OPEN, HOLD and RELEASE; transitions are evaluated per strobe.
REQ-018 CLOSED: gain=0; when level>=open_th, the FSM SHALL go to ATTACK.
REQ-019 ATTACK: rate_cnt SHALL count strobes; when rate_cnt==fx_attack, gain SHALL increment by 1 and rate_cnt SHALL clear; level is ignored in this state; when gain reaches 256 the FSM SHALL go to OPEN.
REQ-020 OPEN: gain=256; when level<close_th, the FSM SHALL go to HOLD and load hold_cnt with fx_hold*64 (13 bit).
REQ-021 HOLD: priority order SHALL be: level>=open_th -> OPEN; else hold_cnt==0 -> RELEASE; else decrement hold_cnt. HOLD therefore lasts fx_hold*64+1 strobes, and gain SHALL stay 256 throughout.
REQ-022 RELEASE: priority order SHALL be: level>=open_th -> ATTACK, continuing from the current gain; else gain SHALL decrement by 1 each time rate_cnt==fx_release; when gain reaches 0 the FSM SHALL go to CLOSED.
REQ-023 rate_cnt SHALL clear on every state entry; a 0 divider means one gain step per strobe.
REQ-024 fx_threshold=0 SHALL make the gate open unconditionally, since level>=0 always holds.
REQ-025 Parameter changes SHALL take effect at the next strobe; a hold_cnt already loaded SHALL NOT be reloaded.
REQ-026 Gain SHALL never wrap past 256 or below 0.

Reset
REQ-027 When reset_n=0 at a clk edge: state=CLOSED, gain=0, rate_cnt=0, hold_cnt=0, audio_out=0 on both channels.
REQ-028 Reset SHALL take priority over sample_en; reset asserted mid-ATTACK or mid-RELEASE SHALL abort to CLOSED with gain=0.

Verification
REQ-029 Reset with audio_in=16'h7FFF and sample_en pulsing -> audio_out=0 while reset_n=0; on the first strobe after release, audio_out=0 (gain 0).
REQ-030 threshold=0x40, attack=0, input L=R=16'h4000 -> ATTACK; audio_out rises by 64 per strobe; OPEN after 256 strobes; then audio_out=16'h4000 exactly.
REQ-031 Gate in OPEN, hold=2, release=1, input drops to 0 at threshold=0x40 -> gain stays 256 for 129 strobes, then decrements every 2 strobes, reaching CLOSED after 512 more strobes.
REQ-032 In RELEASE at gain=100, input 16'h4000 at threshold=0x40 -> ATTACK starts at gain 100; the next output equals (16'h4000*100)>>>8 = 0x1900.
REQ-033 In OPEN, input L=-32768, R=0 -> audio_out L=-32768 bit-exact; level is saturated to 32767 and the gate stays OPEN.
REQ-034 sample_en held low for 50 cycles with changing audio_in -> audio_out, state and gain remain unchanged.
